// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: word/PC types, fetch FSM states,
// and the {pc, instr} entry held in the fetch buffer.
package cpu_pkg;
   typedef logic [31:0] word_t;
   typedef logic [31:0] pc_t;

   localparam word_t NOP_INSTR_DEF = 32'h0000_0013;
   localparam pc_t   RESET_PC_DEF  = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      pc_t   pc;
      word_t instr;
   } fetch_entry_t;
endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory read port: one outstanding word request, acked with data.
interface ifetch_unit_if;
   import cpu_pkg::*;

   logic  imem_req;
   pc_t   imem_addr;
   logic  imem_ack;
   word_t imem_rdata;

   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifetch_fifo.sv
// Circular {pc, instr} buffer with wrapping pointers, a count, and a one-cycle flush.
module ifetch_fifo
   import cpu_pkg::*;
#(
   parameter int  DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     push_data,
   output fetch_entry_t     head,
   output logic [CNT_W-1:0] count
);
   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Storage carries no reset: an entry is only observed once count covers it.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: PC, imem request FSM and fetch buffer feeding IF/ID.
// Define IFETCH_PERF_EN to add the perf_fetched / perf_starve counters.
module ifetch_unit
   import cpu_pkg::*;
#(
   parameter pc_t   RESET_PC  = RESET_PC_DEF,
   parameter word_t NOP_INSTR = NOP_INSTR_DEF,
   parameter int    BUF_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          busy,
   input  logic          redirect_valid,
   input  pc_t           redirect_pc,
   ifetch_unit_if.master imem,
   output word_t         instruction,
   output pc_t           pc_out,
   output logic          tick_ifid
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]   perf_fetched,
   output logic [31:0]   perf_starve
`endif
);
   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   fetch_state_e     state_q, state_d;
   pc_t              pc_q, pc_d;
   logic             req_q, req_d;
   pc_t              addr_q, addr_d;
   logic             push, pop, flush, space;
   logic [CNT_W-1:0] count, count_after;
   fetch_entry_t     head, push_data;
   pc_t              target;

   assign target    = {redirect_pc[31:2], 2'b00};
   assign tick_ifid = (count != '0);
   assign flush     = redirect_valid;
   // A redirect outranks the decode pop: the head being latched is wrong-path.
   assign pop       = tick_ifid && !busy && !redirect_valid;
   assign push      = (state_q == REQ) && imem.imem_ack && !redirect_valid;
   assign push_data = '{pc: addr_q, instr: imem.imem_rdata};

   always_comb begin
      count_after = count;
      if (flush)             count_after = '0;
      else if (push && !pop) count_after = count + CNT_W'(1);
      else if (pop && !push) count_after = count - CNT_W'(1);
   end
   assign space = (count_after < CNT_W'(BUF_DEPTH));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = req_q;
      addr_d  = addr_q;
      case (state_q)
         IDLE: begin
            if (redirect_valid) begin
               pc_d = target;
            end else if (space) begin
               req_d   = 1'b1;
               addr_d  = pc_q;
               state_d = REQ;
            end
         end
         REQ: begin
            if (redirect_valid && imem.imem_ack) begin
               req_d   = 1'b0;
               pc_d    = target;
               state_d = IDLE;
            end else if (redirect_valid) begin
               pc_d    = target;
               state_d = DRAIN;
            end else if (imem.imem_ack) begin
               pc_d = addr_q + 32'd4;
               // Chaining the next address here keeps zero-wait memory at one word per cycle.
               if (space) begin
                  addr_d = addr_q + 32'd4;
               end else begin
                  req_d   = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         DRAIN: begin
            if (redirect_valid) pc_d = target;
            if (imem.imem_ack) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
      end
   end

   ifetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .flush     (flush),
      .push_data (push_data),
      .head      (head),
      .count     (count)
   );

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;
   assign instruction    = tick_ifid ? head.instr : NOP_INSTR;
   assign pc_out         = tick_ifid ? head.pc : '0;

`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_starve_q, perf_starve_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q + (push ? 32'd1 : 32'd0);
      perf_starve_d  = perf_starve_q + ((!busy && !tick_ifid) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q <= '0;
         perf_starve_q  <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_starve_q  <= perf_starve_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_starve  = perf_starve_q;
`endif
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch front end: owns the PC, issues word reads to instruction memory over a req/ack handshake, buffers returned words, and presents them to the IF/ID decode register.
- Downstream contract: decode latches `instruction` on a clock edge where `tick_ifid && !busy`. That edge is also the pop.
- Redirects from execute (branch/jump) flush all buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on `instruction` when the buffer is empty.
- BUF_DEPTH, 2, fetch-buffer entries; power of two, minimum 2.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, synchronous, active-high.
- busy, input, 1, downstream stall; no pop while high.
- redirect_valid, input, 1, one-cycle redirect request.
- redirect_pc, input, 32, redirect target; bits [1:0] ignored (forced 0).
- imem_req, output, 1, memory read request, registered.
- imem_addr, output, 32, word address of request, registered.
- imem_ack, input, 1, request accepted; `imem_rdata` valid this cycle.
- imem_rdata, input, 32, returned instruction word.
- instruction, output, 32, head-of-buffer word, or NOP_INSTR when empty.
- pc_out, output, 32, PC of the head word, or 0 when empty.
- tick_ifid, output, 1, head valid (buffer non-empty); combinational from buffer count.

Behaviour:
- Reset values: pc=RESET_PC; buffer empty (count=0); state=IDLE; imem_req=0; imem_addr=RESET_PC; tick_ifid=0; instruction=NOP_INSTR; pc_out=0. Reset mid-transaction abandons the outstanding request; any later ack is ignored while in IDLE.
- Buffer:
  - Circular FIFO of {pc, instr} with wrapping read/write pointers and a count.
  - Pop when `tick_ifid && !busy`. Push on accepted ack in REQ.
  - Simultaneous push and pop leaves count unchanged; pops from a full buffer and pushes to an empty one are legal in the same cycle.
- Request rules:
  - At most one outstanding request.
  - `imem_req` and `imem_addr` are held stable until `imem_ack`.
  - ack may arrive the same cycle `imem_req` rises (zero wait) or any later cycle.
- Let space = (count − pop + push) < BUF_DEPTH, evaluated on the next-state count.
- FSM, states IDLE, REQ, DRAIN:
  - IDLE:
    - With redirect_valid: pc ← redirect_pc & ~3; stay IDLE.
    - Else, if space: imem_req←1, imem_addr←pc; go to REQ.
  - REQ (request outstanding):
    - On ack without redirect: push {imem_addr, imem_rdata}; pc ← imem_addr+4.
      - If space after push: imem_addr ← imem_addr+4, stay REQ. This gives back-to-back fetch at 1 instr/cycle with zero-wait memory.
      - Else: imem_req←0, go to IDLE.
    - On redirect without ack: go to DRAIN; request held unchanged; pc ← target.
    - On redirect together with ack: data discarded; imem_req←0; pc ← target; go to IDLE.
  - DRAIN:
    - Request held; on ack, data discarded, imem_req←0, go to IDLE.
    - A further redirect in DRAIN only updates pc.
- Redirect effects:
  - Buffer flushed (count←0) in the redirect cycle.
  - Redirect has priority over pop; no pop is counted that cycle.
  - `tick_ifid` is 0 from the next cycle until the new target's word is pushed.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- Full buffer with busy held: no requests; `instruction` and `pc_out` hold the head entry indefinitely.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- When defined: adds outputs `perf_fetched` (32) and `perf_starve` (32), both reset to 0 and wrapping at 2^32.
  - `perf_fetched` increments on each push.
  - `perf_starve` increments each cycle with `!busy && count==0`.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package `cpu_pkg`:
  - NOP_INSTR constant.
  - RESET_PC default.
  - Fetch FSM state enum (IDLE/REQ/DRAIN).
  - Instruction-word and PC width typedefs.
- One natural sub-module, `ifetch_fifo`: parameterized {pc,instr} FIFO with push, pop, flush, count, head outputs.

Test Plan:
- Reset, zero-wait memory (ack tied high, rdata=addr^32'hA5A5_0000), busy=0 → after reset, instructions for pc 0,4,8,… delivered one per cycle; first tick_ifid within 2 cycles.
- busy held high for 10 cycles → exactly 2 words fetched (pc 0,4); imem_req low once full; on busy release, pc 0 then pc 4 pop on consecutive cycles, then fetch resumes at 8.
- 3-cycle ack latency; redirect to 32'h0000_0103 while REQ at addr 8 → imem_addr stays 8 until ack; that data is discarded; next request addr=32'h100; buffer empty, tick_ifid=0 meanwhile.
- Redirect in the same cycle as ack and a pop → no push, buffer flushed, next imem_addr = target.
- pc at 32'hFFFF_FFFC → next request address 32'h0000_0000.
- With IFETCH_PERF_EN, ack delayed 4 cycles per request for 3 fetches, busy=0 → perf_fetched=3; perf_starve equals the counted empty cycles.
